// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: the default operand width, the
// default command-queue depth and the 3-bit opcode encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Default operand/result width and command-queue depth.
  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned ALU_DEPTH = 4;

  // Opcode field width and encodings.
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;  // ~a
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;  // a << 1
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;  // a >> 1, zero fill

endpackage : alu_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU. Computes a WIDTH-bit result (wrapping modulo
// 2^WIDTH) plus zero and carry flags for the eight alu_pkg opcodes.
//
// Ports
//   op     in  [OP_W-1:0]   opcode
//   a, b   in  [WIDTH-1:0]  operands
//   result out [WIDTH-1:0]  a op b
//   zero   out              result == 0
//   carry  out              ADD carry-out, SUB borrow, shifted-out bit, else 0
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  // One extra bit captures the ADD carry-out.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);  // borrow
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = a << 1;
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = a >> 1;
        carry  = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule : alu

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO holding packed ALU commands. The head entry is presented
// combinationally on pop_data so the consumer can compute from it in the same
// cycle it pops. Pushes while full and pops while empty are ignored.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write push_data at the tail
//   push_data   [ENTRY_W-1:0] entry to write
//   pop         retire the head entry
//   pop_data    [ENTRY_W-1:0] current head entry (valid when !empty)
//   empty/full  occupancy status
//   level       [LVL_W-1:0] number of stored entries
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter  int unsigned ENTRY_W = 11,
  parameter  int unsigned DEPTH   = 4,   // power of two, >= 2
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               empty,
  output logic               full,
  output logic [LVL_W-1:0]   level
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q,  count_d;

  logic do_push;
  logic do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LVL_W'(DEPTH));
  assign level   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign pop_data = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) bits wide, so plain increment wraps
  // modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: ;  // idle, or push and pop together: occupancy unchanged
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is carried
  // entirely by the pointers and count, and a reset on the array would only
  // cost a reset net to every storage bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : alu_cmd_fifo

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Queues ALU commands, computes each one from the queue head and holds the
// result in a valid/ready output register. A command accepted at edge N is
// visible on the outputs after edge N+1; with out_ready held high the stage
// sustains one result per cycle.
//
// Ports
//   clk, rst_n               clock and asynchronous active-low reset
//   in_valid / in_ready      command handshake (in_ready = level < DEPTH)
//   in_op, in_a, in_b        opcode and WIDTH-bit operands
//   out_valid / out_ready    result handshake
//   out_result               registered WIDTH-bit result
//   out_zero, out_carry      registered flags
//   sticky_carry             set by any output load with carry = 1
//   clr_sticky               synchronous clear of sticky_carry (set wins)
//   level                    command-queue occupancy
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = ALU_WIDTH,
  parameter  int unsigned DEPTH = ALU_DEPTH,   // power of two, >= 2
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             sticky_carry,
  input  logic             clr_sticky,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned ENTRY_W = OP_W + 2 * WIDTH;

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Held low through reset and released by the first edge afterwards, so
  // in_ready stays 0 while rst_n is low even though the queue reads empty.
  logic accept_en_q, accept_en_d;

  assign in_ready = accept_en_q & ~fifo_full;
  assign push     = in_valid & in_ready;

  alu_cmd_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_op, in_a, in_b}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

  // ---------------------------------------------------------------------------
  // Datapath from the queue head
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0]  head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;

  assign head_op = head[ENTRY_W-1 -: OP_W];
  assign head_a  = head[2*WIDTH-1 -: WIDTH];
  assign head_b  = head[WIDTH-1:0];

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (head_op),
    .a      (head_a),
    .b      (head_b),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             carry_q,     carry_d;
  logic             sticky_q,    sticky_d;

  // The register loads whenever it is empty or being drained this edge;
  // that load is the queue pop.
  assign pop = ~fifo_empty & (~out_valid_q | out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    sticky_d    = sticky_q;
    accept_en_d = 1'b1;

    if (pop) begin
      out_valid_d = 1'b1;
      result_d    = alu_result;
      zero_d      = alu_zero;
      carry_d     = alu_carry;
    end else if (out_ready) begin
      // Handshake with nothing queued behind it.
      out_valid_d = 1'b0;
    end

    // Clear first so that a carry load on the same edge overrides it.
    if (clr_sticky)         sticky_d = 1'b0;
    if (pop && alu_carry)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_en_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      accept_en_q <= accept_en_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_carry    = carry_q;
  assign sticky_carry = sticky_q;

endmodule : alu_issue_stage
